// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package keypad_pkg;

    localparam int COL_W    = 2;
    localparam int NUM_KEYS = 16;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        PRESSED,
        REL_DB
    } kp_state_t;

    // Sweep result: MSB set means no single key was seen; low nibble is the key code.
    localparam logic [4:0] RESULT_NONE = 5'b1_0000;

    // Key code per image bit, image index = col*4 + row; entry 0 is the rightmost element.
    localparam logic [NUM_KEYS-1:0][3:0] KEY_MAP = {
        4'hD, 4'hC, 4'hB, 4'hA,   // column 3, rows 3..0
        4'hE, 4'h9, 4'h6, 4'h3,   // column 2
        4'hF, 4'h8, 4'h5, 4'h2,   // column 1
        4'h0, 4'h7, 4'h4, 4'h1    // column 0
    };

endpackage

// File: rtl/keypad_col_driver.sv
// Column strober: drives one column low at a time and flags the row-sample clock.
// Latency: each column dwells SCAN_CYCLES clocks; a full sweep is 4*SCAN_CYCLES clocks.
// Backpressure: none, free-running.
module keypad_col_driver
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES = 4
) (
    input  logic             clock,
    input  logic             reset,
    output logic [3:0]       col,
    output logic [COL_W-1:0] col_idx,
    output logic             sample,
    output logic             sweep_end
);

    localparam int            DW         = $clog2(SCAN_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);

    logic [DW-1:0] dwell;

    // Dwell counter per column; column index advances after the last dwell clock.
    always_ff @(posedge clock) begin
        if (!reset) begin
            dwell   <= '0;
            col_idx <= '0;
        end else if (dwell == DWELL_LAST) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            dwell   <= dwell + 1'b1;
        end
    end

    assign sample    = (dwell == DWELL_LAST);
    assign sweep_end = sample && (col_idx == 2'd3);
    assign col       = ~(4'b0001 << col_idx);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: synchronises rows, builds a sweep image, debounces whole sweeps into a key code.
// Latency: press/release accepted at the end of the DEBOUNCE_SWEEPS-th identical sweep (<= (N+1) sweeps + 2 clocks).
// Backpressure: none; key_valid is a one-clock pulse, key_held a level.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_SWEEPS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int            CW       = $clog2(DEBOUNCE_SWEEPS + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_SWEEPS);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [COL_W-1:0] col_idx;
    logic             sample;
    logic             sweep_end;
    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [15:0]      image;
    logic [15:0]      image_now;
    logic [4:0]       n_low;
    logic [4:0]       result;
    logic             result_none;
    logic             match_held;
    kp_state_t        state;
    logic [3:0]       cand;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_inc;

    keypad_col_driver #(
        .SCAN_CYCLES (SCAN_CYCLES)
    ) u_col_driver (
        .clock     (clock),
        .reset     (reset),
        .col       (col),
        .col_idx   (col_idx),
        .sample    (sample),
        .sweep_end (sweep_end)
    );

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            row_meta <= 4'hF;
            row_sync <= 4'hF;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
        end
    end

    // Latch the current column's rows into the sweep image on its sample clock.
    always_ff @(posedge clock) begin
        if (!reset) begin
            image <= '1;
        end else if (sample) begin
            image[{col_idx, 2'b00} +: 4] <= row_sync;
        end
    end

    // Sweep evaluation: column 3 is taken live so the result is ready on its sample clock.
    always_comb begin
        image_now        = image;
        image_now[15:12] = row_sync;
        n_low            = '0;
        result           = RESULT_NONE;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (!image_now[4'(i)]) begin
                n_low  = n_low + 5'd1;
                result = {1'b0, KEY_MAP[4'(i)]};
            end
        end
        // Zero or multiple keys (ghosting/rollover) both read as NONE.
        if (n_low != 5'd1) begin
            result = RESULT_NONE;
        end
    end

    assign result_none = result[4];
    assign match_held  = (result == {1'b0, key_code});
    assign cnt_inc     = cnt + 1'b1;

    // Debounce FSM, stepped once per sweep; outputs are registered here.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (sweep_end) begin
                case (state)
                    IDLE: begin
                        if (!result_none) begin
                            cand <= result[3:0];
                            if (CNT_ONE == CNT_DONE) begin
                                state     <= PRESSED;
                                key_code  <= result[3:0];
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= '0;
                            end else begin
                                state <= PRESS_DB;
                                cnt   <= CNT_ONE;
                            end
                        end
                    end
                    PRESS_DB: begin
                        if (result_none) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else if (result[3:0] == cand) begin
                            if (cnt_inc == CNT_DONE) begin
                                state     <= PRESSED;
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt       <= '0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            cand <= result[3:0];
                            cnt  <= CNT_ONE;
                        end
                    end
                    PRESSED: begin
                        if (!match_held) begin
                            if (CNT_ONE == CNT_DONE) begin
                                state    <= IDLE;
                                key_held <= 1'b0;
                                cnt      <= '0;
                            end else begin
                                state <= REL_DB;
                                cnt   <= CNT_ONE;
                            end
                        end
                    end
                    REL_DB: begin
                        if (match_held) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end else if (cnt_inc == CNT_DONE) begin
                            state    <= IDLE;
                            key_held <= 1'b0;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
